uart_rx: RTL and testbench

Serial UART receiver, the receive-side counterpart of the existing uart_tx. Frame format is 8N1: one start bit, 8 data bits LSB first, no parity, one stop bit.
- Synchronises the asynchronous line and validates the start bit at mid-bit.
- Samples each bit once per bit period, checks the stop bit, and holds the received byte until the host acknowledges it.
- Sits between the board RX pin and the NeuroRISC host/peripheral bus logic.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 22 ++
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and helpers.
// Used by uart_rx and uart_tx.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } uart_state_t;

  function automatic logic [7:0] mid_count(input int cpb);
    return 8'((cpb - 1) / 2);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for the serial line.
// Resets to 1 so an idle line does not look like a start bit.
module uart_sync2 (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit start validation,
// stop-bit check and a held byte with ready/overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  input  logic       i_Rx_Ack,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_Rx_Ready,
  output logic       o_Rx_Overrun,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active,
  output logic       o_Rx_Idle,
  output logic [7:0] o_Clock_Count
);

  localparam logic [7:0] MID_COUNT = mid_count(CLKS_PER_BIT);
  localparam logic [7:0] LAST      = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_t state, state_n;
  logic [7:0]  count, count_n;
  logic [2:0]  index, index_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  rx_byte_n;
  logic        dv_n, ready_n, ovr_n, ferr_n, active_n;
  logic        r_Rx;

  uart_sync2 u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .d       (i_Rx_Serial),
    .q       (r_Rx)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= IDLE;
      count          <= '0;
      index          <= '0;
      shift          <= '0;
      o_Rx_Byte      <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Ready     <= 1'b0;
      o_Rx_Overrun   <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Active    <= 1'b0;
    end else begin
      state          <= state_n;
      count          <= count_n;
      index          <= index_n;
      shift          <= shift_n;
      o_Rx_Byte      <= rx_byte_n;
      o_Rx_DV        <= dv_n;
      o_Rx_Ready     <= ready_n;
      o_Rx_Overrun   <= ovr_n;
      o_Rx_Frame_Err <= ferr_n;
      o_Rx_Active    <= active_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    index_n   = index;
    shift_n   = shift;
    rx_byte_n = o_Rx_Byte;
    dv_n      = 1'b0;
    ferr_n    = 1'b0;
    active_n  = o_Rx_Active;
    ready_n   = o_Rx_Ready & ~i_Rx_Ack;
    ovr_n     = o_Rx_Overrun & ~i_Rx_Ack;
    unique case (state)
      IDLE: begin
        count_n = '0;
        index_n = '0;
        if (!r_Rx) state_n = START;
      end
      START: begin
        if (count == MID_COUNT) begin
          count_n = '0;
          if (!r_Rx) begin
            state_n  = DATA;
            active_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          count_n = count + 8'd1;
        end
      end
      DATA: begin
        if (count == LAST) begin
          count_n        = '0;
          shift_n[index] = r_Rx;
          if (index == LAST_BIT) begin
            index_n = '0;
            state_n = STOP;
          end else begin
            index_n = index + 3'd1;
          end
        end else begin
          count_n = count + 8'd1;
        end
      end
      STOP: begin
        if (count == LAST) begin
          count_n  = '0;
          active_n = 1'b0;
          state_n  = CLEANUP;
          if (r_Rx) begin
            rx_byte_n = shift;
            dv_n      = 1'b1;
            ready_n   = 1'b1;
            // an ack in this same cycle consumed the old byte
            if (o_Rx_Ready && !i_Rx_Ack) ovr_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end else begin
          count_n = count + 8'd1;
        end
      end
      CLEANUP: begin
        if (r_Rx) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_Rx_Idle     = (state == IDLE);
  assign o_Clock_Count = count;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 8 clocks per bit.
// Frames are driven bit by bit; a monitor logs DV bytes and errors.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rx_byte;
  logic       dv, ready, ovr, ferr, active, idle;
  logic [7:0] cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int dv_cyc = 0;
  int ferr_cnt = 0;
  int dv_long = 0;
  int max_cnt = 0;
  logic dv_prev = 1'b0;
  logic [7:0] got[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Rst_n        (rst_n),
    .i_Rx_Serial    (rx),
    .i_Rx_Ack       (ack),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_DV        (dv),
    .o_Rx_Ready     (ready),
    .o_Rx_Overrun   (ovr),
    .o_Rx_Frame_Err (ferr),
    .o_Rx_Active    (active),
    .o_Rx_Idle      (idle),
    .o_Clock_Count  (cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dv) begin
      got.push_back(rx_byte);
      dv_cyc = cyc;
      if (dv_prev) dv_long++;
    end
    dv_prev = dv;
    if (ferr) ferr_cnt++;
    if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(CPB);
    end
    rx = stop;
    step(CPB);
  endtask

  task automatic clear_log();
    got.delete();
    ferr_cnt = 0;
  endtask

  function automatic logic [31:0] at(input int i);
    return (got.size() > i) ? 32'(got[i]) : 32'hDEAD;
  endfunction

  initial begin
    #1;
    chk("rst_byte", 32'(rx_byte), 32'h00);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_flags", {27'd0, dv, ready, ovr, ferr, active}, 32'd0);
    step(3);
    rst_n = 1'b1;
    step(3);

    // 0xA5, latency from line-low to DV
    clear_log();
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    step(10);
    chk("a5_n", 32'(got.size()), 32'd1);
    chk("a5_byte", at(0), 32'hA5);
    chk("a5_lat", 32'(dv_cyc - start_cyc), 32'd79);
    chk("a5_ready", 32'(ready), 32'd1);
    chk("a5_ferr", 32'(ferr_cnt), 32'd0);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("a5_ack", 32'(ready), 32'd0);

    // short glitch rejected
    clear_log();
    rx = 1'b0;
    step(2);
    rx = 1'b1;
    step(20);
    chk("gl_idle", 32'(idle), 32'd1);
    chk("gl_ev", 32'(got.size() + ferr_cnt), 32'd0);

    // bad stop bit, line held low
    clear_log();
    send_frame(8'h3C, 1'b0);
    step(20);
    chk("fe_cnt", 32'(ferr_cnt), 32'd1);
    chk("fe_hold", {30'd0, idle, active}, 32'd0);
    chk("fe_byte", 32'(rx_byte), 32'hA5);
    rx = 1'b1;
    step(5);
    chk("fe_idle", 32'(idle), 32'd1);
    step(100);
    chk("fe_nostart", 32'(got.size() + ferr_cnt), 32'd1);

    // overrun
    clear_log();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(10);
    chk("ov_n", 32'(got.size()), 32'd2);
    chk("ov_byte", 32'(rx_byte), 32'h22);
    chk("ov_flags", {30'd0, ready, ovr}, 32'd3);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("ov_ack", {30'd0, ready, ovr}, 32'd0);

    // async reset during data bit 4
    clear_log();
    fork
      send_frame(8'h5A, 1'b1);
      begin
        step(8 * 5 + 4);
        chk("rs_act", 32'(active), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("rs_byte", 32'(rx_byte), 32'h00);
        chk("rs_flags", {27'd0, dv, ready, ovr, ferr, active}, 32'd0);
        chk("rs_idle", 32'(idle), 32'd1);
        chk("rs_cnt", 32'(cnt), 32'd0);
      end
    join
    rx = 1'b1;
    step(2);
    chk("rs_ev", 32'(got.size() + ferr_cnt), 32'd0);
    rst_n = 1'b1;
    step(5);
    send_frame(8'h5A, 1'b1);
    step(10);
    chk("rs_5a", at(0), 32'h5A);
    chk("rs_5a_n", 32'(got.size()), 32'd1);

    // back-to-back frames
    clear_log();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    step(10);
    chk("bb_n", 32'(got.size()), 32'd2);
    chk("bb_b0", at(0), 32'h00);
    chk("bb_b1", at(1), 32'hFF);
    chk("bb_ferr", 32'(ferr_cnt), 32'd0);

    chk("dv_width", 32'(dv_long), 32'd0);
    chk("cnt_max", 32'(max_cnt), 32'(CPB - 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
